// File: rtl/mul_share_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_ctrl_if
//  Description : Request/response and multiplier-side bus of mul_share_ctrl.
//                master = the controller, slave = requesters + multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
interface mul_share_ctrl_if;
    // Requester 0
    logic        req0_valid;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_ready;
    logic        rsp0_valid;
    logic        rsp0_err;
    // Requester 1
    logic        req1_valid;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_ready;
    logic        rsp1_valid;
    logic        rsp1_err;
    // Shared response data
    logic [31:0] rsp_data;
    // Multiplier side
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_out;
    logic        mul_valid;
    // Status
    logic        busy;

    modport master (
        input  req0_valid, req0_a, req0_b,
        output req0_ready, rsp0_valid, rsp0_err,
        input  req1_valid, req1_a, req1_b,
        output req1_ready, rsp1_valid, rsp1_err,
        output rsp_data,
        output mul_start, mul_a, mul_b,
        input  mul_out, mul_valid,
        output busy
    );

    modport slave (
        output req0_valid, req0_a, req0_b,
        input  req0_ready, rsp0_valid, rsp0_err,
        output req1_valid, req1_a, req1_b,
        input  req1_ready, rsp1_valid, rsp1_err,
        input  rsp_data,
        input  mul_start, mul_a, mul_b,
        output mul_out, mul_valid,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_ctrl
//  Description : Round-robin arbiter sharing one sequential 16x16 signed
//                multiplier between two requesters, with completion timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_share_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  wire logic         CLK,
    input  wire logic         reset,
    mul_share_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_ptr;       // requester that currently has priority
    logic               r_owner;     // requester owning the operation in flight
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_mul_a;
    logic [15:0]        r_mul_b;
    logic [31:0]        r_rsp_data;

    logic               w_grant_valid;
    logic               w_grant;
    logic               w_accept;
    logic               w_timeout;

    // Priority to r_ptr when it is requesting, otherwise fall back to the other one.
    // Ready is masked during reset so no handshake is offered while held in reset.
    always_comb begin
        w_grant_valid = bus.req0_valid | bus.req1_valid;
        w_grant       = r_ptr ? bus.req1_valid : ~bus.req0_valid;
        w_accept      = (r_state == S_IDLE) && w_grant_valid && !reset;
        w_timeout     = (r_cnt == c_CNT_LAST);
    end

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a result in the same cycle as the timeout counts as a result.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_START;
            S_START: w_next_state = S_WAIT;
            S_WAIT:  if (bus.mul_valid || w_timeout) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand latch, wait counter, result capture and round-robin pointer update.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ptr      <= 1'b0;
            r_owner    <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant;
                        r_mul_a <= w_grant ? bus.req1_a : bus.req0_a;
                        r_mul_b <= w_grant ? bus.req1_b : bus.req0_b;
                    end
                end
                S_START: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.mul_valid) begin
                        r_rsp_data <= bus.mul_out;
                        r_err      <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_err      <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_ptr <= ~r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode.
    always_comb begin
        bus.req0_ready = w_accept && !w_grant;
        bus.req1_ready = w_accept &&  w_grant;
        bus.rsp0_valid = (r_state == S_RESP) && !r_owner;
        bus.rsp1_valid = (r_state == S_RESP) &&  r_owner;
        bus.rsp0_err   = (r_state == S_RESP) && !r_owner && r_err;
        bus.rsp1_err   = (r_state == S_RESP) &&  r_owner && r_err;
        bus.rsp_data   = r_rsp_data;
        bus.mul_start  = (r_state == S_START);
        bus.mul_a      = r_mul_a;
        bus.mul_b      = r_mul_b;
        bus.busy       = (r_state != S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_share_ctrl
//  Description : Directed self-checking bench for mul_share_ctrl with a
//                variable-latency multiplier model and response scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_share_ctrl;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    mul_share_ctrl_if bus ();

    mul_share_ctrl #(.TIMEOUT(64), .CNT_W(8)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Multiplier model: lat = number of WAIT cycles until mul_valid, 0 = never
    // ------------------------------------------------------------------
    int          lat = 17;
    int          mcnt = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_out = '0;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_out = '0;
    logic signed [31:0] ma, mb;

    assign bus.mul_valid = m_valid | inj_valid;
    assign bus.mul_out   = inj_valid ? inj_out : m_out;

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            mcnt    = 0;
            m_valid = 1'b0;
        end else begin
            #1;
            m_valid = 1'b0;
            if (bus.mul_start) begin
                mcnt  = lat;
                ma    = $signed(bus.mul_a);
                mb    = $signed(bus.mul_b);
                m_out = ma * mb;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) m_valid = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor + scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int          cyc = 0, hs_count = 0, rsp_seen = 0, hs_owner = 0;
    int          hs_cyc = 0, start_cyc = 0, mv_cyc = 0;
    int          ready0_cycles = 0, rsp1_count = 0;
    logic [15:0] hs_a = '0, hs_b = '0;
    bit          busy_chk = 1'b0;
    bit          exp_to = 1'b0;
    logic signed [31:0] pa, pb;

    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            if (busy_chk) begin
                chk("busy_after_rsp", bus.busy, 1'b0);
                busy_chk = 1'b0;
            end
            if (bus.req0_ready && bus.req1_ready) chk("ready_onehot", 2, 1);
            if (bus.req0_ready) ready0_cycles++;
            if (bus.rsp1_valid) rsp1_count++;
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
                hs_owner = bus.req1_ready ? 1 : 0;
                hs_a     = bus.req1_ready ? bus.req1_a : bus.req0_a;
                hs_b     = bus.req1_ready ? bus.req1_b : bus.req0_b;
                hs_cyc   = cyc;
                hs_count++;
                pa = $signed(hs_a);
                pb = $signed(hs_b);
                e.owner = hs_owner;
                e.err   = exp_to;
                e.data  = exp_to ? 32'd0 : pa * pb;
                sb.push_back(e);
            end
            if (bus.mul_start) begin
                chk("start_latency", cyc, hs_cyc + 1);
                start_cyc = cyc;
            end
            if (bus.busy) begin
                chk("mul_a_stable", bus.mul_a, hs_a);
                chk("mul_b_stable", bus.mul_b, hs_b);
                if (bus.mul_valid) mv_cyc = cyc;
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                rsp_seen++;
                busy_chk = 1'b1;
                chk("rsp_onehot", bus.rsp0_valid & bus.rsp1_valid, 1'b0);
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", bus.rsp1_valid ? 1 : 0, e.owner);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_err", bus.rsp1_valid ? bus.rsp1_err : bus.rsp0_err, e.err);
                    if (e.err) chk("timeout_latency", cyc, start_cyc + 1 + 64);
                    else       chk("rsp_latency", cyc, mv_cyc + 1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_hs(input int target);
        int k = 0;
        while (hs_count < target && k < 200) begin
            @(posedge CLK); #2;
            k++;
        end
        chk("hs_wait_bound", hs_count >= target, 1'b1);
    endtask

    task automatic wait_rsp(input int target);
        int k = 0;
        while (rsp_seen < target && k < 300) begin
            @(posedge CLK); #2;
            k++;
        end
        chk("rsp_wait_bound", rsp_seen >= target, 1'b1);
        @(posedge CLK); #2;
    endtask

    task automatic do_req(input int n, input logic [15:0] a, input logic [15:0] b);
        int t = hs_count + 1;
        if (n == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end
        wait_hs(t);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic do_both();
        int t = hs_count;
        int r = rsp_seen;
        bus.req0_a = 16'd123;            bus.req0_b = 16'(-7);
        bus.req1_a = 16'(-1);            bus.req1_b = 16'(-60);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        wait_hs(t + 1);
        chk("both_first_owner", hs_owner, 0);
        bus.req0_valid = 1'b0;
        wait_hs(t + 2);
        chk("both_second_owner", hs_owner, 1);
        bus.req1_valid = 1'b0;
        wait_rsp(r + 2);
        chk("both_last_data", bus.rsp_data, 32'd60);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int r;
        bus.req0_valid = 1'b1; bus.req0_a = 16'd3; bus.req0_b = 16'd9;
        bus.req1_valid = 1'b0; bus.req1_a = '0;    bus.req1_b = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req0_ready", bus.req0_ready, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mul_start", bus.mul_start, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_mul_ab", {bus.mul_a, bus.mul_b}, 32'd0);
        chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        @(posedge CLK); #2;

        // single requester 0
        r = rsp_seen + 1;
        do_req(0, 16'd3, 16'd9);
        wait_rsp(r);
        chk("t1_data", bus.rsp_data, 32'd27);
        chk("t1_ready_cycles", ready0_cycles, 1);
        chk("t1_no_rsp1", rsp1_count, 0);

        // requester 1, negative product then zero
        r = rsp_seen + 1;
        do_req(1, 16'(-10001), 16'd14);
        wait_rsp(r);
        chk("t2_data", bus.rsp_data, 32'hFFFDDD12);
        r = rsp_seen + 1;
        do_req(1, 16'd0, 16'd11);
        wait_rsp(r);
        chk("t2_zero", bus.rsp_data, 32'd0);

        // simultaneous requests, twice
        lat = 5;
        do_both();
        do_both();

        // never-completing multiplier -> timeout
        lat = 0;
        exp_to = 1'b1;
        r = rsp_seen + 1;
        do_req(0, 16'd100, 16'd100);
        wait_rsp(r);
        exp_to = 1'b0;
        chk("t4_data", bus.rsp_data, 32'd0);

        // result on the last counter value wins over the timeout
        lat = 64;
        r = rsp_seen + 1;
        do_req(1, 16'd7, 16'(-3));
        wait_rsp(r);
        chk("t5_data", bus.rsp_data, 32'hFFFFFFEB);

        // spurious mul_valid while idle
        r = rsp_seen;
        @(negedge CLK);
        inj_out = 32'h1234_5678;
        inj_valid = 1'b1;
        repeat (5) @(negedge CLK);
        inj_valid = 1'b0;
        repeat (3) @(posedge CLK); #2;
        chk("t6_no_rsp", rsp_seen, r);
        chk("t6_hold_data", bus.rsp_data, 32'hFFFFFFEB);
        chk("t6_busy", bus.busy, 1'b0);

        // reset while waiting
        lat = 0;
        do_req(0, 16'd7, 16'd7);
        repeat (5) @(posedge CLK);
        #2;
        chk("t7_busy_before", bus.busy, 1'b1);
        r = rsp_seen;
        @(negedge CLK); #2;
        reset = 1'b1;
        #1;
        chk("t7_busy", bus.busy, 1'b0);
        chk("t7_mul_ab", {bus.mul_a, bus.mul_b}, 32'd0);
        chk("t7_rsp_data", bus.rsp_data, 32'd0);
        chk("t7_mul_start", bus.mul_start, 1'b0);
        sb.delete();
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        lat = 17;
        repeat (5) @(posedge CLK); #2;
        chk("t7_no_rsp", rsp_seen, r);
        r = rsp_seen + 1;
        do_req(0, 16'd5, 16'(-5));
        wait_rsp(r);
        chk("t7_data", bus.rsp_data, 32'hFFFFFFE7);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
